fetch_queue_unit: RTL and testbench

Decoupled, parametrised instruction fetch front end for the BRISC-V core. It issues pipelined word reads to the instruction memory, with up to MAX_OUTSTANDING reads in flight. Returned instructions are buffered in a DEPTH-entry prefetch queue that feeds decode through a valid/ready handshake. It handles redirects (branch/JAL/JALR resolved elsewhere) and interrupt entry by discarding stale in-flight responses with an epoch tag, in place of stall-and-replay.

---
 rtl/fetch_defs.sv | 19 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_queue_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_queue_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_defs.sv
// Shared definitions for the fetch front end: FSM encodings and the bit layout
// of the in-flight tracker and prefetch queue entries.
package fetch_defs;

  typedef enum logic {
    FQ_IDLE = 1'b0,
    FQ_RUN  = 1'b1
  } fq_state_e;

  // Tracker entry {PC, epoch, int_flag}, LSB first.
  localparam int TRK_INT_POS   = 0;
  localparam int TRK_EPOCH_POS = 1;
  localparam int TRK_PC_LSB    = 2;

  // Queue entry {instruction, PC, int_flag}, LSB first; instruction sits above PC.
  localparam int QUE_INT_POS   = 0;
  localparam int QUE_PC_LSB    = 1;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count; pushes into a full
// FIFO and pops from an empty one are ignored.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  assign do_push  = push && (count < DEPTH_C) && !flush;
  assign do_pop   = pop && (count != '0) && !flush;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; validity comes from count, so it needs no reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Decoupled instruction fetch: pipelined word reads into a prefetch queue, with
// redirects and interrupt entry handled by epoch-tagging in-flight reads.
module fetch_queue_unit
  import fetch_defs::*;
#(
  parameter int CORE            = 0,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_BITS    = 20,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDRESS_BITS-1:0] program_address,
  input  logic                    redirect_valid,
  input  logic [ADDRESS_BITS-1:0] redirect_target,
  input  logic                    interrupt_valid,
  input  logic [ADDRESS_BITS-1:0] interrupt_PC,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDRESS_BITS-1:0] mem_req_addr,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_instruction,
  output logic [ADDRESS_BITS-1:0] out_PC,
  output logic                    out_interrupt,
  input  logic                    report
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int OW    = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SW    = ((CW > OW) ? CW : OW) + 1;
  localparam int TRK_W = ADDRESS_BITS + 2;
  localparam int QUE_W = DATA_WIDTH + ADDRESS_BITS + 1;

  fq_state_e               state;
  fq_state_e               state_next;
  logic [ADDRESS_BITS-1:0] fetch_PC;
  logic                    epoch;
  logic                    pending_int;
  logic [CW-1:0]           count;
  logic [OW-1:0]           outstanding;
  logic [SW-1:0]           in_use;

  logic                    flush;
  logic                    int_take;
  logic [ADDRESS_BITS-1:0] flush_target;
  logic                    req_fire;
  logic                    rsp_fire;
  logic                    que_push;
  logic                    que_pop;
  logic [TRK_W-1:0]        trk_rd;
  logic [QUE_W-1:0]        que_rd;
  logic                    trk_current;

  assign int_take     = (state == FQ_RUN) && interrupt_valid;
  assign flush        = (state == FQ_RUN) && (interrupt_valid || redirect_valid || start);
  assign flush_target = interrupt_valid ? interrupt_PC :
                        redirect_valid  ? redirect_target : program_address;

  assign in_use   = SW'(count) + SW'(outstanding);
  assign req_fire = mem_req_valid && mem_req_ready;
  // Responses with nothing tracked (e.g. stragglers after a reset) are ignored.
  assign rsp_fire = mem_rsp_valid && (outstanding != '0);

  assign trk_current = (trk_rd[TRK_EPOCH_POS] == epoch);
  assign que_push    = rsp_fire && trk_current && !flush;
  assign que_pop     = out_valid && out_ready && !flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= FQ_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == FQ_IDLE && start) state_next = FQ_RUN;
  end

  always_comb begin
    mem_req_valid = (state == FQ_RUN) &&
                    (outstanding < OW'(MAX_OUTSTANDING)) &&
                    (in_use < SW'(DEPTH));
  end

  assign mem_req_addr = fetch_PC >> 2;

  // A request accepted in a flush cycle keeps the old epoch and is dropped on return.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_PC    <= '0;
      epoch       <= 1'b0;
      pending_int <= 1'b0;
    end else if (state == FQ_IDLE) begin
      if (start) fetch_PC <= program_address;
    end else if (flush) begin
      fetch_PC    <= flush_target;
      epoch       <= ~epoch;
      pending_int <= int_take;
    end else if (req_fire) begin
      fetch_PC    <= fetch_PC + ADDRESS_BITS'(4);
      pending_int <= 1'b0;
    end
  end

  fetch_fifo #(
    .WIDTH (TRK_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tracker (
    .clock     (clock),
    .reset     (reset),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data ({fetch_PC, epoch, pending_int}),
    .pop       (rsp_fire),
    .pop_data  (trk_rd),
    .count     (outstanding)
  );

  fetch_fifo #(
    .WIDTH (QUE_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (que_push),
    .push_data ({mem_rsp_data, trk_rd[TRK_PC_LSB +: ADDRESS_BITS], trk_rd[TRK_INT_POS]}),
    .pop       (que_pop),
    .pop_data  (que_rd),
    .count     (count)
  );

  // Head fields are masked while empty so the outputs read zero after reset.
  assign out_valid       = (count != '0);
  assign out_instruction = out_valid ? que_rd[QUE_PC_LSB + ADDRESS_BITS +: DATA_WIDTH] : '0;
  assign out_PC          = out_valid ? que_rd[QUE_PC_LSB +: ADDRESS_BITS] : '0;
  assign out_interrupt   = out_valid && que_rd[QUE_INT_POS];

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (report)
      $display("fetch_queue_unit core %0d: state=%0d fetch_PC=%h epoch=%0b count=%0d outstanding=%0d pending_int=%0b",
               CORE, state, fetch_PC, epoch, count, outstanding, pending_int);
  end

  a_rsp_tracked: assert property (@(posedge clock) disable iff (!reset)
    !(mem_rsp_valid && outstanding == '0));
  a_count_bound: assert property (@(posedge clock) disable iff (!reset)
    count <= CW'(DEPTH));
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scenario bench for fetch_queue_unit: a queue-backed memory model answers reads,
// and expected {PC, interrupt} entries are scoreboarded against decode-side pops.
module tb_fetch_queue_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [19:0] program_address;
  logic        redirect_valid;
  logic [19:0] redirect_target;
  logic        interrupt_valid;
  logic [19:0] interrupt_PC;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [19:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [19:0] out_PC;
  logic        out_interrupt;
  logic        report;

  logic        rsp_hold;
  int          issued;
  logic [19:0] pend [$];
  logic [19:0] rsp_addr;

  typedef struct {
    logic [19:0] pc;
    logic        intr;
  } exp_t;
  exp_t sb [$];
  exp_t e;

  int total = 0;
  int bad   = 0;

  fetch_queue_unit dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .program_address (program_address),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .interrupt_valid (interrupt_valid),
    .interrupt_PC    (interrupt_PC),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_data    (mem_rsp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_PC          (out_PC),
    .out_interrupt   (out_interrupt),
    .report          (report)
  );

  always #5 clock = ~clock;

  // Memory: in-order, one response per cycle, 1-cycle latency unless held.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend.delete();
      issued        <= 0;
      mem_rsp_valid <= 1'b0;
      mem_rsp_data  <= '0;
    end else begin
      if (mem_req_valid && mem_req_ready) begin
        pend.push_back(mem_req_addr);
        issued <= issued + 1;
      end
      if (!rsp_hold && pend.size() != 0) begin
        rsp_addr = pend.pop_front();
        mem_rsp_valid <= 1'b1;
        mem_rsp_data  <= {12'hABC, 2'b00, rsp_addr[17:0]};
      end else begin
        mem_rsp_valid <= 1'b0;
      end
    end
  end

  function automatic logic [31:0] instr_of(input logic [19:0] pc);
    return {12'hABC, 2'b00, pc[19:2]};
  endfunction

  task automatic push_run(input logic [19:0] pc0, input int n, input logic first_int);
    for (int i = 0; i < n; i++) begin
      e.pc   = pc0 + 20'(4 * i);
      e.intr = (i == 0) ? first_int : 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0; program_address = '0;
    redirect_valid = 1'b0; redirect_target = '0;
    interrupt_valid = 1'b0; interrupt_PC = '0;
    mem_req_ready = 1'b1; out_ready = 1'b0; report = 1'b0; rsp_hold = 1'b0;
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0; program_address = '0;
    redirect_valid = 1'b0; redirect_target = '0;
    interrupt_valid = 1'b0; interrupt_PC = '0;
    mem_req_ready = 1'b1; out_ready = 1'b0; report = 1'b0; rsp_hold = 1'b0;
    repeat (2) @(negedge clock);
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%0b want=0", mem_req_valid); end
    total++; if (mem_req_addr !== 20'h0) begin bad++; $display("FAIL reset_req_addr got=%h want=0", mem_req_addr); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (out_instruction !== 32'h0) begin bad++; $display("FAIL reset_out_instr got=%h want=0", out_instruction); end
    total++; if (out_PC !== 20'h0) begin bad++; $display("FAIL reset_out_pc got=%h want=0", out_PC); end
    total++; if (out_interrupt !== 1'b0) begin bad++; $display("FAIL reset_out_int got=%0b want=0", out_interrupt); end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL idle_no_fetch got=%0b want=0", mem_req_valid); end
  endtask

  task automatic test_boot_stream();
    int first_k = -1;
    int last_k  = -1;
    do_reset();
    out_ready = 1'b1;
    program_address = 20'h00100;
    start = 1'b1;
    push_run(20'h00100, 8, 1'b0);
    for (int k = 0; k < 40 && sb.size() > 0; k++) begin
      if (k == 1) start = 1'b0;
      if (out_valid && first_k < 0) first_k = k;
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        last_k = k;
        total++;
        if (out_PC !== e.pc || out_instruction !== instr_of(e.pc) || out_interrupt !== e.intr) begin
          bad++; $display("FAIL boot_pop got pc=%h ins=%h int=%0b want pc=%h ins=%h int=%0b",
                          out_PC, out_instruction, out_interrupt, e.pc, instr_of(e.pc), e.intr);
        end
      end
      @(negedge clock);
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL boot_timeout left=%0d want=0", sb.size()); end
    total++; if (first_k != 3) begin bad++; $display("FAIL boot_latency got=%0d want=3", first_k); end
    total++; if (last_k != first_k + 7) begin bad++; $display("FAIL boot_rate got_last=%0d want=%0d", last_k, first_k + 7); end
  endtask

  task automatic test_backpressure();
    int last_k = -1;
    do_reset();
    program_address = 20'h00200;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (12) @(negedge clock);
    total++; if (issued != 4) begin bad++; $display("FAIL bp_issued got=%0d want=4", issued); end
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_req_stall got=%0b want=0", mem_req_valid); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid got=%0b want=1", out_valid); end
    out_ready = 1'b1;
    push_run(20'h00200, 8, 1'b0);
    for (int k = 0; k < 40 && sb.size() > 0; k++) begin
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        last_k = k;
        total++;
        if (out_PC !== e.pc || out_instruction !== instr_of(e.pc) || out_interrupt !== e.intr) begin
          bad++; $display("FAIL bp_pop got pc=%h ins=%h int=%0b want pc=%h int=%0b",
                          out_PC, out_instruction, out_interrupt, e.pc, e.intr);
        end
      end
      @(negedge clock);
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL bp_timeout left=%0d want=0", sb.size()); end
    total++; if (last_k != 7) begin bad++; $display("FAIL bp_rate got_last=%0d want=7", last_k); end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    out_ready = 1'b1;
    rsp_hold = 1'b1;
    program_address = 20'h00108;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    total++; if (issued != 2) begin bad++; $display("FAIL redir_inflight got=%0d want=2", issued); end
    redirect_valid = 1'b1;
    redirect_target = 20'h00400;
    @(negedge clock);
    redirect_valid = 1'b0;
    rsp_hold = 1'b0;
    push_run(20'h00400, 3, 1'b0);
    for (int k = 0; k < 40 && sb.size() > 0; k++) begin
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        total++;
        if (out_PC !== e.pc || out_instruction !== instr_of(e.pc) || out_interrupt !== e.intr) begin
          bad++; $display("FAIL redir_pop got pc=%h ins=%h int=%0b want pc=%h int=%0b",
                          out_PC, out_instruction, out_interrupt, e.pc, e.intr);
        end
      end
      @(negedge clock);
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL redir_timeout left=%0d want=0", sb.size()); end
  endtask

  task automatic test_interrupt_priority();
    do_reset();
    program_address = 20'h00100;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    interrupt_valid = 1'b1; interrupt_PC = 20'h00080;
    redirect_valid = 1'b1;  redirect_target = 20'h00400;
    @(negedge clock);
    interrupt_valid = 1'b0;
    redirect_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL int_flush got=%0b want=0", out_valid); end
    out_ready = 1'b1;
    push_run(20'h00080, 3, 1'b1);
    for (int k = 0; k < 40 && sb.size() > 0; k++) begin
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        total++;
        if (out_PC !== e.pc || out_instruction !== instr_of(e.pc) || out_interrupt !== e.intr) begin
          bad++; $display("FAIL int_pop got pc=%h ins=%h int=%0b want pc=%h int=%0b",
                          out_PC, out_instruction, out_interrupt, e.pc, e.intr);
        end
      end
      @(negedge clock);
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL int_timeout left=%0d want=0", sb.size()); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    out_ready = 1'b1;
    program_address = 20'hFFFFC;
    start = 1'b1;
    e.pc = 20'hFFFFC; e.intr = 1'b0; sb.push_back(e);
    push_run(20'h00000, 2, 1'b0);
    for (int k = 0; k < 40 && sb.size() > 0; k++) begin
      if (k == 1) start = 1'b0;
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        total++;
        if (out_PC !== e.pc || out_instruction !== instr_of(e.pc) || out_interrupt !== e.intr) begin
          bad++; $display("FAIL wrap_pop got pc=%h ins=%h want pc=%h ins=%h",
                          out_PC, out_instruction, e.pc, instr_of(e.pc));
        end
      end
      @(negedge clock);
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL wrap_timeout left=%0d want=0", sb.size()); end
  endtask

  task automatic test_async_reset();
    do_reset();
    program_address = 20'h00100;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    rsp_hold = 1'b1;
    repeat (4) @(negedge clock);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL areset_pre_valid got=%0b want=1", out_valid); end
    #2 reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || mem_req_valid !== 1'b0 || out_PC !== 20'h0 ||
                 out_instruction !== 32'h0 || out_interrupt !== 1'b0 || mem_req_addr !== 20'h0) begin
      bad++; $display("FAIL areset_outputs got v=%0b rq=%0b pc=%h ins=%h int=%0b addr=%h want all 0",
                      out_valid, mem_req_valid, out_PC, out_instruction, out_interrupt, mem_req_addr);
    end
    @(negedge clock);
    reset = 1'b1;
    rsp_hold = 1'b0;
    @(negedge clock);
    out_ready = 1'b1;
    program_address = 20'h00300;
    start = 1'b1;
    push_run(20'h00300, 3, 1'b0);
    for (int k = 0; k < 40 && sb.size() > 0; k++) begin
      if (k == 1) start = 1'b0;
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        total++;
        if (out_PC !== e.pc || out_instruction !== instr_of(e.pc) || out_interrupt !== e.intr) begin
          bad++; $display("FAIL areset_pop got pc=%h ins=%h want pc=%h", out_PC, out_instruction, e.pc);
        end
      end
      @(negedge clock);
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL areset_timeout left=%0d want=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_boot_stream();
    test_backpressure();
    test_redirect_inflight();
    test_interrupt_priority();
    test_pc_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
